octal_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource between 8 requesters.
//  The winner is reported as a one-hot grant and as a 3-bit binary index (octal digit).
//  An internal one-hot-to-binary encoder produces the index.

---
 rtl/arb_pkg.sv | 6 +
 rtl/onehot8_encoder.sv | 11 +
 rtl/octal_rr_arbiter.sv | 75 +++++++
 tb/tb_octal_rr_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and FSM state type for the octal round-robin arbiter
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/onehot8_encoder.sv
// onehot8_encoder: 8-bit one-hot to 3-bit binary, flags zero or multiple set bits
module onehot8_encoder
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             invalid
);
  assign idx = {|(onehot & 8'hF0), |(onehot & 8'hCC), |(onehot & 8'hAA)};
  assign invalid = $countones(onehot) != 1;
endmodule

// File: rtl/octal_rr_arbiter.sv
// octal_rr_arbiter: 8-way round-robin arbiter with registered one-hot and binary grant
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles.
module octal_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);
  arb_state_t       state;
  logic [IDX_W-1:0] last_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win;
  logic             held;
  logic             limit;
  if (MAX_HOLD < 2 || CNT_W != $clog2(MAX_HOLD)) begin : g_bad_cfg
    $error("octal_rr_arbiter: MAX_HOLD must be >= 2 and CNT_W must not be overridden");
  end
  assign held = req[grant_idx];
  // Scan from farthest to nearest so the requester closest after last_ptr wins.
  always_comb begin
    win = '0;
    for (int i = N_REQ; i >= 1; i--)
      if (req[IDX_W'(int'(last_ptr) + i)]) win = N_REQ'(1) << IDX_W'(int'(last_ptr) + i);
  end
  onehot8_encoder u_enc (
    .onehot (win),
    .idx    (win_idx),
    .invalid()
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      last_ptr    <= IDX_W'(N_REQ - 1);
    end else if (state == ARB_IDLE) begin
      if (|req) begin
        state       <= ARB_GRANT;
        grant       <= win;
        grant_idx   <= win_idx;
        grant_valid <= 1'b1;
        last_ptr    <= win_idx;
      end
    end else if (!held || limit) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  assign limit = hold_cnt == CNT_W'(MAX_HOLD - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= (state == ARB_GRANT) ? hold_cnt + 1'b1 : '0;
      timeout  <= (state == ARB_GRANT) && held && limit;
    end
  end
`else
  assign limit   = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_octal_rr_arbiter.sv
// tb_octal_rr_arbiter: vector table, corner sequences and random traffic vs a reference model
module tb_octal_rr_arbiter;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  int total = 0;
  int bad = 0;
  bit m_busy, m_to;
  int m_owner, m_last, m_held;
  typedef struct {
    logic [7:0] req;
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
  } vec_t;
  vec_t tbl[13];
  octal_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 7; m_held = 0; m_to = 0;
  endtask
  task automatic model_edge();
    m_to = 0;
    if (!m_busy) begin
      for (int k = 1; k <= 8; k++) begin
        int c = (m_last + k) % 8;
        if (!m_busy && req[c]) begin
          m_owner = c; m_busy = 1; m_held = 1; m_last = c;
        end
      end
    end else if (!req[m_owner]) m_busy = 0;
    else if (TO && m_held == MH) begin
      m_busy = 0; m_to = 1;
    end else m_held++;
  endtask
  task automatic cmp(string nm, logic [7:0] g, logic [2:0] i, logic v, logic t);
    total++;
    if ({grant, grant_idx, grant_valid, timeout} !== {g, i, v, t}) begin
      bad++;
      $display("FAIL %s: got grant=%b idx=%0d valid=%b timeout=%b, want grant=%b idx=%0d valid=%b timeout=%b",
               nm, grant, grant_idx, grant_valid, timeout, g, i, v, t);
    end
  endtask
  task automatic check_model(string nm);
    cmp(nm, m_busy ? 8'(1 << m_owner) : 8'h00, 3'(m_owner), m_busy, m_to);
  endtask
  task automatic check_inv(string nm);
    total++;
    if (!($onehot0(grant) && (grant_valid == |grant) && (!grant_valid || grant == (8'h01 << grant_idx)))) begin
      bad++;
      $display("FAIL %s invariant: grant=%b idx=%0d valid=%b", nm, grant, grant_idx, grant_valid);
    end
  endtask
  task automatic step(string nm);
    @(posedge clk);
    model_edge();
    #1;
    check_model(nm);
    check_inv(nm);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    cmp("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, time=%0t", $time);
    $fatal(1);
  end
  initial begin
    int n;
    tbl[0]  = '{8'h01, 8'h01, 3'd0, 1'b1};
    tbl[1]  = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[2]  = '{8'h14, 8'h04, 3'd2, 1'b1};
    tbl[3]  = '{8'h14, 8'h04, 3'd2, 1'b1};
    tbl[4]  = '{8'h10, 8'h00, 3'd2, 1'b0};
    tbl[5]  = '{8'h10, 8'h10, 3'd4, 1'b1};
    tbl[6]  = '{8'h00, 8'h00, 3'd4, 1'b0};
    tbl[7]  = '{8'h40, 8'h40, 3'd6, 1'b1};
    tbl[8]  = '{8'h00, 8'h00, 3'd6, 1'b0};
    tbl[9]  = '{8'h81, 8'h80, 3'd7, 1'b1};
    tbl[10] = '{8'h01, 8'h00, 3'd7, 1'b0};
    tbl[11] = '{8'h01, 8'h01, 3'd0, 1'b1};
    tbl[12] = '{8'h00, 8'h00, 3'd0, 1'b0};
    do_reset();
    for (int k = 0; k < 13; k++) begin
      req = tbl[k].req;
      @(posedge clk);
      model_edge();
      #1;
      cmp($sformatf("vec%0d", k), tbl[k].g, tbl[k].i, tbl[k].v, 1'b0);
      check_inv($sformatf("vec%0d", k));
    end
    req = 8'h20;
    step("t5_grant");
    cmp("t5_idx5", 8'h20, 3'd5, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("t5_async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h21;
    @(negedge clk);
    rst_n = 1'b1;
    step("t5_after_reset");
    cmp("t5_idx0_first", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    for (int k = 0; k < 20; k++) step("t6_idle");
    if (TO) begin
      do_reset();
      req = 8'h11;
      n = 0;
      for (int k = 0; k < 20; k++) begin
        step("t4_timeout");
        if (timeout) n++;
      end
      total++;
      if (n != 4) begin
        bad++;
        $display("FAIL t4_pulses: got %0d timeout pulses, want 4", n);
      end
      req = 8'h00;
      step("t4_release");
    end
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      step("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
